// File: rtl/halt_dump_ctrl.sv
// Halt detector + data-RAM dump engine: on HALT_WORD drain DRAIN cycles, freeze CPU, stream DEPTH words.
// Latency: freeze DRAIN edges after halt; 3 cycles/word min; backpressure holds dump_data/dump_valid until dump_ready. Optional HALT_DUMP_CYCLES_EN appends cycle count.
module halt_dump_ctrl #(
    parameter int          DEPTH     = 512,
    parameter int          AW        = 9,
    parameter int          DW        = 32,
    parameter int          DRAIN     = 3,
    parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
    input  logic          CLOCK,
    input  logic          reset,
    input  logic [31:0]   instruction,
    output logic          cpu_freeze,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] dump_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          dump_last,
    output logic          done,
    output logic [31:0]   cycles
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_READ,
        S_CAPT,
        S_HOLD,
`ifdef HALT_DUMP_CYCLES_EN
        S_STAT,
`endif
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [3:0]    DRAIN_LOAD = 4'(DRAIN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [3:0]    cnt;
    logic          hs;
    logic          is_last_addr;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        hs           = dump_valid & dump_ready;
        is_last_addr = (addr == LAST_ADDR);
        case (state)
            S_RUN:   if (instruction == HALT_WORD) state_nxt = S_DRAIN;
            S_DRAIN: if (cnt == 4'd0) state_nxt = S_READ;
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr;
                state_nxt = S_CAPT;
            end
            S_CAPT:  state_nxt = S_HOLD;
            S_HOLD: begin
                if (hs) begin
                    if (!is_last_addr) state_nxt = S_READ;
`ifdef HALT_DUMP_CYCLES_EN
                    else               state_nxt = S_STAT;
`else
                    else               state_nxt = S_DONE;
`endif
                end
            end
`ifdef HALT_DUMP_CYCLES_EN
            S_STAT:  if (hs) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            cycles     <= '0;
            addr       <= '0;
            cnt        <= '0;
            cpu_freeze <= 1'b0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    cycles <= cycles + 32'd1;
                    if (instruction == HALT_WORD) cnt <= DRAIN_LOAD;
                end
                S_DRAIN: begin
                    cycles <= cycles + 32'd1;
                    if (cnt == 4'd0) cpu_freeze <= 1'b1;
                    else             cnt        <= cnt - 4'd1;
                end
                S_CAPT: begin
                    dump_data  <= mem_rdata;
                    dump_valid <= 1'b1;
`ifdef HALT_DUMP_CYCLES_EN
                    dump_last  <= 1'b0;
`else
                    dump_last  <= is_last_addr;
`endif
                end
                S_HOLD: begin
                    if (hs) begin
                        dump_valid <= 1'b0;
                        if (!is_last_addr) begin
                            addr <= addr + AW'(1);
                        end else begin
`ifdef HALT_DUMP_CYCLES_EN
                            // Trailing status word carries the frozen cycle count
                            dump_data  <= DW'(cycles);
                            dump_valid <= 1'b1;
                            dump_last  <= 1'b1;
`else
                            dump_last  <= 1'b0;
                            done       <= 1'b1;
`endif
                        end
                    end
                end
`ifdef HALT_DUMP_CYCLES_EN
                S_STAT: begin
                    if (hs) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    done       <= 1'b1;
                    cpu_freeze <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Randomized bench for halt_dump_ctrl: expected dump stream and cycle count built from the program shape.
module tb_halt_dump_ctrl;

    localparam int          DEPTH = 512;
    localparam int          AW    = 9;
    localparam int          DW    = 32;
    localparam int          DRAIN = 3;
    localparam logic [31:0] HALT  = 32'hffffffff;
`ifdef HALT_DUMP_CYCLES_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic          CLOCK = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instruction = '0;
    logic          cpu_freeze;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] dump_data;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic          dump_last;
    logic          done;
    logic [31:0]   cycles;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] ram [DEPTH];

    halt_dump_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .DRAIN(DRAIN), .HALT_WORD(HALT)) dut (
        .CLOCK(CLOCK), .reset(reset), .instruction(instruction), .cpu_freeze(cpu_freeze),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_last(dump_last), .done(done), .cycles(cycles)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 4);

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        instruction = '0;
        dump_ready  = 1'b0;
        repeat (5) step();
        reset = 1'b1;
    endtask

    // Runs one program (n_x X cycles, n_pre ordinary instructions, halt) and checks the dump.
    task automatic run_dump(input string name, input int n_x, input int n_pre,
                            input bit rand_ready, input int abort_word);
        int            cyc_exp;
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        logic [31:0]   r;
        int            e, got, first_e, last_hs_e;
        bit            held, held_l, rdy;
        logic [DW-1:0] held_d;

        cyc_exp = n_x + n_pre + 1 + DRAIN;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d.push_back(ram[i]);
            exp_l.push_back(STAT_EN ? 1'b0 : (i == DEPTH - 1));
        end
        if (STAT_EN) begin
            exp_d.push_back(DW'(cyc_exp));
            exp_l.push_back(1'b1);
        end

        apply_reset();
        for (int i = 0; i < n_x; i++) begin
            instruction = 'x;
            step();
        end
        for (int i = 0; i < n_pre; i++) begin
            do r = $urandom; while (r == HALT);
            instruction = r;
            step();
        end
        instruction = HALT;
        step();
        for (int j = 0; j <= DRAIN; j++) begin
            vectors++;
            if (cpu_freeze !== (j == DRAIN)) begin
                errors++;
                $display("FAIL %s freeze_timing drain_edge=%0d got=%b want=%b", name, j, cpu_freeze, j == DRAIN);
            end
            if (j < DRAIN) begin
                instruction = $urandom;
                step();
            end
        end
        vectors++;
        if (cycles !== cyc_exp) begin
            errors++;
            $display("FAIL %s cycles_at_freeze got=%0d want=%0d", name, cycles, cyc_exp);
        end

        e = 0; got = 0; first_e = -1; last_hs_e = -1; held = 0; held_l = 0; held_d = '0;
        while (done !== 1'b1 && e < 20000) begin
            if (held) begin
                vectors++;
                if (dump_valid !== 1'b1 || dump_data !== held_d || dump_last !== held_l) begin
                    errors++;
                    $display("FAIL %s hold_stable word=%0d valid=%b data=%h last=%b want data=%h last=%b",
                             name, got, dump_valid, dump_data, dump_last, held_d, held_l);
                end
            end
            if (mem_rd_en !== 1'b1) begin
                vectors++;
                if (mem_addr !== '0) begin
                    errors++;
                    $display("FAIL %s idle_addr got=%0d want=0", name, mem_addr);
                end
            end
            if (dump_valid === 1'b1 && first_e < 0) begin
                first_e = e;
                vectors++;
                if (e != 2) begin
                    errors++;
                    $display("FAIL %s first_valid_delay got=%0d want=2", name, e);
                end
            end
            if (abort_word >= 0 && got == abort_word && dump_valid === 1'b1) begin
                reset = 1'b0;
                #1;
                vectors++;
                if ({cpu_freeze, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last, done, cycles} !== '0) begin
                    errors++;
                    $display("FAIL %s async_abort freeze=%b rd=%b addr=%0d data=%h valid=%b last=%b done=%b cycles=%0d want all 0",
                             name, cpu_freeze, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last, done, cycles);
                end
                return;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            dump_ready  = rdy;
            instruction = $urandom;
            if (dump_valid === 1'b1 && rdy) begin
                vectors++;
                if (got >= exp_d.size()) begin
                    errors++;
                    $display("FAIL %s extra_word idx=%0d data=%h want none", name, got, dump_data);
                end else if (dump_data !== exp_d[got] || dump_last !== exp_l[got]) begin
                    errors++;
                    $display("FAIL %s word idx=%0d got data=%h last=%b want data=%h last=%b",
                             name, got, dump_data, dump_last, exp_d[got], exp_l[got]);
                end
                if (!rand_ready && last_hs_e >= 0) begin
                    vectors++;
                    if (e - last_hs_e != 3) begin
                        errors++;
                        $display("FAIL %s word_spacing idx=%0d got=%0d want=3", name, got, e - last_hs_e);
                    end
                end
                last_hs_e = e;
                got++;
                held = 0;
            end else begin
                held   = (dump_valid === 1'b1);
                held_d = dump_data;
                held_l = dump_last;
            end
            step();
            e++;
        end
        vectors++;
        if (e >= 20000) begin
            errors++;
            $display("FAIL %s timeout got=%0d words want done", name, got);
        end
        vectors++;
        if (got != exp_d.size()) begin
            errors++;
            $display("FAIL %s word_count got=%0d want=%0d", name, got, exp_d.size());
        end
        vectors++;
        if (e - last_hs_e != 1) begin
            errors++;
            $display("FAIL %s done_delay got=%0d want=1", name, e - last_hs_e);
        end
        dump_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if (done !== 1'b1 || cpu_freeze !== 1'b1 || mem_rd_en !== 1'b0 || dump_valid !== 1'b0 || cycles !== cyc_exp) begin
            errors++;
            $display("FAIL %s final_state done=%b freeze=%b rd=%b valid=%b cycles=%0d want 1 1 0 0 %0d",
                     name, done, cpu_freeze, mem_rd_en, dump_valid, cycles, cyc_exp);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        instruction = '0;
        dump_ready  = 1'b0;
        repeat (5) step();
        vectors++;
        if ({cpu_freeze, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last, done, cycles} !== '0) begin
            errors++;
            $display("FAIL reset_state freeze=%b rd=%b addr=%0d data=%h valid=%b last=%b done=%b cycles=%0d want all 0",
                     cpu_freeze, mem_rd_en, mem_addr, dump_data, dump_valid, dump_last, done, cycles);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (cycles !== 32'd1 || cpu_freeze !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cycles=%0d freeze=%b want 1 0", cycles, cpu_freeze);
        end
    endtask

    task automatic test_basic_dump();
        run_dump("basic", 0, 10, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_dump("backpressure", 0, 10, 1'b1, -1);
    endtask

    task automatic test_abort_restart();
        run_dump("abort", 0, 10, 1'b0, 200);
        run_dump("rerun", 0, 10, 1'b0, -1);
    endtask

    task automatic test_x_instr();
        run_dump("x_instr", 4, 5, 1'b0, -1);
    endtask

    task automatic test_first_edge_halt();
        run_dump("first_edge", 0, 0, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_backpressure();
        test_abort_restart();
        test_x_instr();
        test_first_edge_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
